// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam int unsigned ACT_W = 4;
  localparam int unsigned FLG_W = 4;

  localparam logic [ACT_W-1:0] OP_ADD = 4'd0;
  localparam logic [ACT_W-1:0] OP_SUB = 4'd1;
  localparam logic [ACT_W-1:0] OP_AND = 4'd2;
  localparam logic [ACT_W-1:0] OP_OR  = 4'd3;
  localparam logic [ACT_W-1:0] OP_XOR = 4'd4;
  localparam logic [ACT_W-1:0] OP_SHL = 4'd5;
  localparam logic [ACT_W-1:0] OP_SHR = 4'd6;
  localparam logic [ACT_W-1:0] OP_NOT = 4'd7;
  localparam logic [ACT_W-1:0] OP_ADC = 4'd8;
  localparam logic [ACT_W-1:0] OP_SBB = 4'd9;
  localparam logic [ACT_W-1:0] OP_SAR = 4'd10;
  localparam logic [ACT_W-1:0] OP_MUL = 4'd11;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [ACT_W-1:0] act;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic [FLG_W-1:0] flags;
  logic             illegal;

  modport master (
    output in_valid, op1, op2, act, cin, out_ready,
    input  in_ready, out_valid, res, res_hi, flags, illegal
  );

  modport slave (
    input  in_valid, op1, op2, act, cin, out_ready,
    output in_ready, out_valid, res, res_hi, flags, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned multiplier: one multiplier bit per clock, LSB first.
// done is high during the final iteration; prod then carries the complete product
// so the caller can capture it on the same edge the last partial sum is added.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Next partial sum and last-iteration detect.
  always_comb begin
    prod = acc + (mplier[0] ? mcand : '0);
    done = busy && (cnt == CW'(WIDTH - 1));
  end

  // Load operands on start, then shift-add once per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with Z/N/C/V flags and an optional iterative MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int M = WIDTH - 1;

  state_t             state;
  logic               rdy_en;
  logic               ov_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic [FLG_W-1:0]   fl_q;
  logic               ill_q;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [FLG_W-1:0]   mul_flags;

  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        dif;
  logic [WIDTH:0]        shl_t;
  logic [WIDTH:0]        shr_t;
  logic signed [WIDTH:0] sar_t;
  logic                  big_sh;
  logic [WIDTH-1:0]      sc_res;
  logic                  sc_c;
  logic                  sc_v;
  logic                  sc_ill;
  logic [FLG_W-1:0]      sc_flags;

  assign bus.in_ready  = rdy_en & ((state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready));
  assign bus.out_valid = ov_q;
  assign bus.res       = res_q;
  assign bus.res_hi    = hi_q;
  assign bus.flags     = fl_q;
  assign bus.illegal   = ill_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign is_mul = (bus.act == OP_MUL) && MUL_EN;

  generate
    if (MUL_EN) begin : g_mul
      logic mul_start;
      assign mul_start = accept & is_mul;
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.op1),
        .b     (bus.op2),
        .done  (mul_done),
        .prod  (prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign prod     = '0;
    end
  endgenerate

  // MUL flags are taken over the full double-width product.
  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_Z] = (prod == '0);
    mul_flags[FLG_N] = prod[2*WIDTH-1];
    mul_flags[FLG_C] = (prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLG_V] = (prod[2*WIDTH-1:WIDTH] != '0);
  end

  // Single-cycle datapath. Right shifts run on {op1,0} so the bit shifted
  // out lands in bit 0; left shift on {0,op1} puts it in the top bit.
  always_comb begin
    sum    = {1'b0, bus.op1} + {1'b0, bus.op2} + {{WIDTH{1'b0}}, (bus.act == OP_ADC) & bus.cin};
    dif    = {1'b0, bus.op1} - {1'b0, bus.op2} - {{WIDTH{1'b0}}, (bus.act == OP_SBB) & bus.cin};
    shl_t  = {1'b0, bus.op1} << bus.op2;
    shr_t  = {bus.op1, 1'b0} >> bus.op2;
    sar_t  = $signed({bus.op1, 1'b0}) >>> bus.op2;
    big_sh = (bus.op2 >= WIDTH'(WIDTH));
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (bus.act)
      OP_ADD, OP_ADC: begin
        sc_res = sum[M:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.op1[M] == bus.op2[M]) && (sum[M] != bus.op1[M]);
      end
      OP_SUB, OP_SBB: begin
        sc_res = dif[M:0];
        sc_c   = dif[WIDTH];
        sc_v   = (bus.op1[M] != bus.op2[M]) && (dif[M] != bus.op1[M]);
      end
      OP_AND: sc_res = bus.op1 & bus.op2;
      OP_OR:  sc_res = bus.op1 | bus.op2;
      OP_XOR: sc_res = bus.op1 ^ bus.op2;
      OP_NOT: sc_res = ~bus.op1;
      OP_SHL: begin
        if (!big_sh) begin
          sc_res = shl_t[M:0];
          sc_c   = shl_t[WIDTH];
        end
      end
      OP_SHR: begin
        if (!big_sh) begin
          sc_res = shr_t[WIDTH:1];
          sc_c   = shr_t[0];
        end
      end
      OP_SAR: begin
        if (big_sh) begin
          sc_res = {WIDTH{bus.op1[M]}};
          sc_c   = bus.op1[M];
        end else begin
          sc_res = sar_t[WIDTH:1];
          sc_c   = sar_t[0];
        end
      end
      OP_MUL:  sc_ill = !MUL_EN;
      default: sc_ill = 1'b1;
    endcase
    sc_flags = '0;
    if (!sc_ill) begin
      sc_flags[FLG_Z] = (sc_res == '0);
      sc_flags[FLG_N] = sc_res[M];
      sc_flags[FLG_C] = sc_c;
      sc_flags[FLG_V] = sc_v;
    end
  end

  // Handshake FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
      ov_q   <= 1'b0;
      res_q  <= '0;
      hi_q   <= '0;
      fl_q   <= '0;
      ill_q  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_BUSY;
              ov_q  <= 1'b0;
            end else begin
              state <= ST_DONE;
              ov_q  <= 1'b1;
              res_q <= sc_res;
              hi_q  <= '0;
              fl_q  <= sc_flags;
              ill_q <= sc_ill;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state <= ST_IDLE;
            ov_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state <= ST_DONE;
            ov_q  <= 1'b1;
            res_q <= prod[WIDTH-1:0];
            hi_q  <= prod[2*WIDTH-1:WIDTH];
            fl_q  <= mul_flags;
            ill_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16), with a MUL_EN=0 instance for illegal decode.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) a_if ();
  alu_seq_if #(.WIDTH(16)) b_if ();

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic set_a(input logic [3:0] a, input logic [15:0] x, input logic [15:0] y, input logic ci);
    a_if.act = a; a_if.op1 = x; a_if.op2 = y; a_if.cin = ci; a_if.in_valid = 1'b1;
  endtask

  // Reference model written from the opcode definitions, using integer arithmetic.
  function automatic exp_t model(input logic [3:0] a, input logic [15:0] x, input logic [15:0] y, input logic ci);
    exp_t e;
    int unsigned ux, uy, cu, full;
    int sx, sy, sr, n;
    longint unsigned p;
    logic [15:0] r;
    logic c, v;
    ux = x; uy = y; cu = ci; sx = $signed(x); sy = $signed(y);
    r = '0; c = 1'b0; v = 1'b0; e = '0;
    case (a)
      4'd0, 4'd8: begin
        if (a == 4'd0) cu = 0;
        full = ux + uy + cu; r = full[15:0]; c = full[16];
        sr = sx + sy + int'(cu); v = (sr > 32767) || (sr < -32768);
      end
      4'd1, 4'd9: begin
        if (a == 4'd1) cu = 0;
        full = ux - uy - cu; r = full[15:0]; c = (ux < uy + cu);
        sr = sx - sy - int'(cu); v = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd7: r = ~x;
      4'd5: if (uy < 16) begin r = x << uy; if (uy != 0) c = x[16 - uy]; end
      4'd6: if (uy < 16) begin r = x >> uy; if (uy != 0) c = x[uy - 1]; end
      4'd10: begin
        n = (uy >= 16) ? 16 : int'(uy);
        r = x;
        for (int k = 0; k < n; k++) begin c = r[0]; r = {r[15], r[15:1]}; end
      end
      4'd11: begin
        p = longint'(ux) * longint'(uy);
        e.res = p[15:0]; e.hi = p[31:16];
        e.fl = {p[31:16] != 0, p[31:16] != 0, p[31], p == 0};
        return e;
      end
      default: begin e.ill = 1'b1; return e; end
    endcase
    e.res = r; e.fl = {v, c, r[15], r == 16'h0};
    return e;
  endfunction

  task automatic test_reset;
    exp_t obs;
    rst_n = 1'b0;
    a_if.in_valid = 0; a_if.out_ready = 1; set_a(4'd0, 16'h0, 16'h0, 1'b0); a_if.in_valid = 0;
    b_if.in_valid = 0; b_if.out_ready = 1; b_if.act = 0; b_if.op1 = 0; b_if.op2 = 0; b_if.cin = 0;
    repeat (2) @(negedge clk);
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (obs !== '0 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_state got=%h ov=%b want=0", obs, a_if.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_if.in_ready); end
  endtask

  task automatic test_back_to_back;
    exp_t e, obs;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin set_a(OP_ADD, 16'h7FFF, 16'h0001, 1'b0); q.push_back({16'h8000, 16'h0, 4'hA, 1'b0}); end
        1: begin set_a(OP_SUB, 16'h0000, 16'h0001, 1'b0); q.push_back({16'hFFFF, 16'h0, 4'h6, 1'b0}); end
        default: begin set_a(OP_ADC, 16'hFFFF, 16'h0000, 1'b1); q.push_back({16'h0000, 16'h0, 4'h5, 1'b0}); end
      endcase
      #1;
      total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready op=%0d got=%b want=1", i, a_if.in_ready); end
      @(posedge clk); @(negedge clk);
      total++; if (a_if.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid op=%0d got=%b want=1", i, a_if.out_valid); end
      e = q.pop_front();
      obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
      total++; if (obs !== e) begin bad++; $display("FAIL b2b_result op=%0d got=%h want=%h", i, obs, e); end
    end
    a_if.in_valid = 1'b0;
    @(negedge clk);
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", a_if.out_valid); end
  endtask

  task automatic test_shifts;
    exp_t e, obs;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin set_a(OP_SHL, 16'h8001, 16'd1, 1'b0);  q.push_back({16'h0002, 16'h0, 4'h4, 1'b0}); end
        1: begin set_a(OP_SAR, 16'h8000, 16'd20, 1'b0); q.push_back({16'hFFFF, 16'h0, 4'h6, 1'b0}); end
        default: begin set_a(OP_SHR, 16'h8000, 16'd16, 1'b0); q.push_back({16'h0000, 16'h0, 4'h1, 1'b0}); end
      endcase
      @(posedge clk); @(negedge clk);
      e = q.pop_front();
      obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
      total++; if (a_if.out_valid !== 1'b1 || obs !== e) begin bad++; $display("FAIL shift op=%0d got=%h ov=%b want=%h", i, obs, a_if.out_valid, e); end
    end
    a_if.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    exp_t e, obs;
    int cnt;
    logic rdy_bad;
    set_a(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
    q.push_back({16'h0001, 16'hFFFE, 4'hE, 1'b0});
    @(posedge clk); @(negedge clk);
    set_a(OP_ADD, 16'h1111, 16'h2222, 1'b0);
    cnt = 1; rdy_bad = 1'b0;
    while (a_if.out_valid !== 1'b1 && cnt < 40) begin
      if (a_if.in_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    a_if.in_valid = 1'b0;
    total++; if (cnt != 17) begin bad++; $display("FAIL mul_latency got=%0d want=17", cnt); end
    total++; if (rdy_bad !== 1'b0) begin bad++; $display("FAIL mul_busy_in_ready got=1 want=0"); end
    e = q.pop_front();
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (obs !== e) begin bad++; $display("FAIL mul_result got=%h want=%h", obs, e); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    exp_t e, obs;
    a_if.out_ready = 1'b0;
    set_a(OP_XOR, 16'hAAAA, 16'h5555, 1'b0);
    q.push_back({16'hFFFF, 16'h0, 4'h2, 1'b0});
    @(posedge clk); @(negedge clk);
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
      total++; if (a_if.out_valid !== 1'b1 || obs !== q[0] || a_if.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold cyc=%0d got=%h ov=%b rdy=%b want=%h ov=1 rdy=0", i, obs, a_if.out_valid, a_if.in_ready, q[0]);
      end
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    set_a(OP_ADD, 16'd1, 16'd2, 1'b0);
    q.push_back({16'h0003, 16'h0, 4'h0, 1'b0});
    #1;
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", a_if.in_ready); end
    e = q.pop_front();
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (obs !== e) begin bad++; $display("FAIL release_first got=%h want=%h", obs, e); end
    @(posedge clk); @(negedge clk);
    a_if.in_valid = 1'b0;
    e = q.pop_front();
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (a_if.out_valid !== 1'b1 || obs !== e) begin bad++; $display("FAIL release_second got=%h ov=%b want=%h", obs, a_if.out_valid, e); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    exp_t e, obs;
    set_a(4'd13, 16'h1234, 16'h5678, 1'b1);
    q.push_back({16'h0, 16'h0, 4'h0, 1'b1});
    @(posedge clk); @(negedge clk);
    a_if.in_valid = 1'b0;
    e = q.pop_front();
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (a_if.out_valid !== 1'b1 || obs !== e) begin bad++; $display("FAIL illegal_13 got=%h ov=%b want=%h", obs, a_if.out_valid, e); end
    b_if.act = OP_MUL; b_if.op1 = 16'd300; b_if.op2 = 16'd300; b_if.cin = 1'b0; b_if.in_valid = 1'b1;
    q.push_back({16'h0, 16'h0, 4'h0, 1'b1});
    @(posedge clk); @(negedge clk);
    b_if.in_valid = 1'b0;
    e = q.pop_front();
    obs = {b_if.res, b_if.res_hi, b_if.flags, b_if.illegal};
    total++; if (b_if.out_valid !== 1'b1 || obs !== e) begin bad++; $display("FAIL illegal_nomul got=%h ov=%b want=%h", obs, b_if.out_valid, e); end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t e, obs;
    int issued = 0;
    for (int cyc = 0; cyc < 3000 && (issued < 60 || q.size() > 0); cyc++) begin
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      if (issued < 60) begin
        set_a(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom), 1'($urandom));
        a_if.in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        a_if.in_valid = 1'b0;
      end
      #1;
      if (a_if.out_valid && a_if.out_ready) begin
        obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL rand_spurious got=%h want=none", obs);
        end else begin
          e = q.pop_front();
          total++; if (obs !== e) begin bad++; $display("FAIL rand_result got=%h want=%h", obs, e); end
        end
      end
      if (a_if.in_valid && a_if.in_ready) begin
        q.push_back(model(a_if.act, a_if.op1, a_if.op2, a_if.cin));
        issued++;
      end
      @(negedge clk);
    end
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d want=0", q.size()); end
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    exp_t obs;
    int spur;
    set_a(OP_ADD, 16'd5, 16'd6, 1'b0);
    @(posedge clk); @(negedge clk);
    a_if.in_valid = 1'b0;
    total++; if (a_if.res !== 16'd11) begin bad++; $display("FAIL pre_mul_add got=%h want=000b", a_if.res); end
    @(negedge clk);
    set_a(OP_MUL, 16'd300, 16'd300, 1'b0);
    @(posedge clk); @(negedge clk);
    a_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {a_if.res, a_if.res_hi, a_if.flags, a_if.illegal};
    total++; if (obs !== '0 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL async_reset got=%h ov=%b want=0", obs, a_if.out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b want=1", a_if.in_ready); end
    spur = 0;
    repeat (25) begin
      if (a_if.out_valid !== 1'b0) spur++;
      @(negedge clk);
    end
    total++; if (spur != 0) begin bad++; $display("FAIL mid_reset_spurious got=%0d want=0", spur); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shifts();
    test_mul();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked, parametrised-width ALU for the next RedCPU datapath generation.
- Keeps the existing 8-operation opcode set at codes 0-7 and adds carry-in arithmetic, arithmetic shift right and an iterative unsigned multiply.
- Produces Z/N/C/V flags.
- Sits between the register-file read stage and writeback; valid/ready on both sides, so the execute stage can stall on MUL.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 4).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL decoded as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand / shift amount.
- act  in  4  opcode.
- cin  in  1  carry/borrow in, used by ADC/SBB only.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- res  out  WIDTH  result (MUL: low half).
- res_hi  out  WIDTH  MUL high half; 0 for all other ops.
- flags  out  4  {V,C,N,Z}, bit 0 = Z.
- illegal  out  1  completed op had an undefined opcode.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; res=0; res_hi=0; flags=0; illegal=0.
  - A MUL in progress is abandoned with no output.
  - in_ready=1 one cycle after rst_n deasserts synchronously.
- States:
  - IDLE: no result held.
  - BUSY: MUL iterating.
  - DONE: result held.
- Accept = in_valid & in_ready, sampled on the rising edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Single-cycle ops sustain one per clock.
- Single-cycle ops (all except MUL): on accept, result/flags registered; state=DONE; out_valid=1 from the next cycle (latency 1).
- MUL:
  - Accept -> BUSY, count=0.
  - Shift-add one op2 bit per clock (LSB first).
  - After WIDTH iterations -> DONE, so out_valid is asserted WIDTH+1 cycles after accept.
  - in_ready=0 throughout BUSY.
- DONE & out_ready & !accept -> IDLE, out_valid=0. DONE & out_ready & accept -> next op (DONE or BUSY).
- Holding: while out_valid & !out_ready, res/res_hi/flags/illegal stay stable.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 NOT(op1).
  - 8 ADC = op1+op2+cin; 9 SBB = op1-op2-cin.
  - 10 SAR (arithmetic right); 11 MUL (unsigned).
  - 12-15 illegal: res=0, res_hi=0, flags=0, illegal=1, latency 1. MUL with MUL_EN=0 is handled the same way.
- Arithmetic: computed at WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH.
  - SUB/SBB: C = borrow (1 when op1 < op2+cin unsigned).
  - V = signed overflow for 0,1,8,9; 0 for all other ops except MUL.
- Shifts: amount = op2 unsigned.
  - amount >= WIDTH: SHL/SHR -> 0; SAR -> all bits = op1 MSB.
  - C = last bit shifted out (amount >= WIDTH: SHL/SHR C=0, SAR C=op1 MSB); amount 0 -> C=0.
- Logic ops and NOT: C=0, V=0.
- Z = (res==0) for all ops. MUL: Z = ({res_hi,res}==0).
- N = res[WIDTH-1]. MUL: N = res_hi[WIDTH-1].
- MUL: C = V = (res_hi != 0).
- Inputs are sampled only at accept; changes afterwards have no effect.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_MUL), flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3), state encoding (ST_IDLE, ST_BUSY, ST_DONE).
- Sub-module alu_mul_iter (start, operands, done, 2*WIDTH product; WIDTH-cycle shift-add). alu_seq owns the handshake, the single-cycle datapath and the flags.

Test Plan:
- Reset mid-MUL: accept MUL 300*300, drop rst_n at cycle 5 -> outputs 0 asynchronously; after release in_ready=1, no spurious out_valid.
- Back-to-back, out_ready=1: ADD 0x7FFF+1, SUB 0x0000-1, ADC 0xFFFF+0+cin=1, one per clock ->
  - res=0x8000, flags V=1 N=1 C=0 Z=0.
  - res=0xFFFF, C=1 N=1 V=0.
  - res=0x0000, C=1 Z=1.
  - Each one cycle after its accept.
- MUL 0xFFFF*0xFFFF -> out_valid exactly 17 cycles after accept; res=0x0001, res_hi=0xFFFE, C=V=1, N=1, Z=0; in_ready=0 during BUSY.
- Shifts:
  - SHL 0x8001 by 1 -> res 0x0002, C=1.
  - SAR 0x8000 by 20 -> res 0xFFFF, C=1.
  - SHR 0x8000 by 16 -> res 0, Z=1, C=0.
- Backpressure: out_ready=0 for 5 cycles after XOR 0xAAAA^0x5555 -> res 0xFFFF held stable, in_ready=0; raise out_ready with a new op waiting -> both transfer the same edge.
- Illegal: act=13 -> illegal=1, res=0, flags=0; MUL_EN=0 build with act=11 -> same.
